// File: rtl/friscv_dmem_responder.sv
// ---------------------------------------------------------------------------
// friscv_dmem_responder
//
// Responder side of the core data-memory interface. This block holds a
// word-organised storage array and answers one access at a time through
// the state sequence IDLE -> WAIT (0..15 wait states) -> RESP.
//
// Handshake: the initiator raises mem_en and holds mem_en, mem_wr,
// mem_addr, mem_wdata and mem_strb stable. The request is captured on the
// first rising edge seen in IDLE. Completion is the single cycle in which
// mem_ready=1, which happens in RESP while mem_en is still high. Dropping
// mem_en before that cycle abandons the access: no write is committed and
// mem_rdata keeps its old value.
//
// Ports
//   aclk       in   clock, rising edge
//   srst       in   synchronous active-high reset (storage is not cleared)
//   mem_en     in   request active
//   mem_wr     in   1 = write, 0 = read
//   mem_addr   in   byte address, word index = mem_addr[log2(DEPTH)+1:2]
//   mem_wdata  in   write data
//   mem_strb   in   per-byte write enables (ignored for reads)
//   mem_rdata  out  read data, held until the next read completes
//   mem_ready  out  one-cycle completion pulse
//   busy       out  high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module friscv_dmem_responder #(
    parameter int ADDRW       = 16,
    parameter int XLEN        = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              aclk,
    input  logic              srst,
    input  logic              mem_en,
    input  logic              mem_wr,
    input  logic [ADDRW-1:0]  mem_addr,
    input  logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN/8-1:0] mem_strb,
    output logic [XLEN-1:0]   mem_rdata,
    output logic              mem_ready,
    output logic              busy
);

    localparam int         LP_IDXW     = $clog2(DEPTH);
    localparam logic [3:0] LP_CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_next;
    logic                w_capture;
    logic                w_complete;
    logic                w_rd_done;
    logic                w_wr_done;

    logic                r_wr;
    logic [LP_IDXW-1:0]  r_idx;
    logic [XLEN-1:0]     r_wdata;
    logic [XLEN/8-1:0]   r_strb;
    logic [XLEN-1:0]     r_rdata;
    logic [XLEN-1:0]     r_mem [DEPTH];

    // Address bits outside the word index are intentionally ignored.
    logic                w_unused_addr;
    assign w_unused_addr = ^mem_addr;

    // ------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_en) begin
                    w_capture = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        w_next_state = WAIT;
                        w_cnt_next   = LP_CNT_INIT;
                    end else begin
                        w_next_state = RESP;
                    end
                end
            end
            WAIT: begin
                if (!mem_en) begin
                    w_next_state = IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_next_state = RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            RESP: begin
                // Completion only counts while the initiator still holds
                // the request; otherwise this cycle is an abort.
                w_complete   = mem_en;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_rd_done = w_complete & ~r_wr;
    assign w_wr_done = w_complete &  r_wr;

    assign mem_ready = w_complete;
    assign busy      = (r_state != IDLE);

    // The stored word is shown directly in the completing read cycle and
    // latched into r_rdata on the edge that leaves RESP, so an aborted
    // read never disturbs the held value.
    assign mem_rdata = w_rd_done ? r_mem[r_idx] : r_rdata;

    // ------------------------------------------------------------------
    // State, counter and read-data register
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (srst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            if (w_rd_done) begin
                r_rdata <= r_mem[r_idx];
            end
        end
    end

    // Request capture; only the registered copy is used for the access.
    always_ff @(posedge aclk) begin
        if (!srst && w_capture) begin
            r_wr    <= mem_wr;
            r_idx   <= mem_addr[LP_IDXW+1:2];
            r_wdata <= mem_wdata;
            r_strb  <= mem_strb;
        end
    end

    // Storage: no reset; a reset in flight suppresses the commit.
    always_ff @(posedge aclk) begin
        if (!srst && w_wr_done) begin
            for (int b = 0; b < XLEN/8; b++) begin
                if (r_strb[b]) begin
                    r_mem[r_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_friscv_dmem_responder.sv
// ---------------------------------------------------------------------------
// Bench for friscv_dmem_responder. Three instances with WAIT_CYCLES of
// 1 (slot 0), 0 (slot 1) and 3 (slot 2) share one clock; each has its own
// stimulus signals. Expected read data is pushed to exp_q when a request
// is driven and popped when mem_ready is observed.
// ---------------------------------------------------------------------------
module tb_friscv_dmem_responder;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        srst  [3];
    logic        en    [3];
    logic        wr    [3];
    logic [15:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  strb  [3];
    logic [31:0] rdata [3];
    logic        ready [3];
    logic        busy  [3];

    genvar g;
    for (g = 0; g < 3; g++) begin : g_dut
        friscv_dmem_responder #(
            .ADDRW       (16),
            .XLEN        (32),
            .DEPTH       (1024),
            .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .aclk      (clk),
            .srst      (srst[g]),
            .mem_en    (en[g]),
            .mem_wr    (wr[g]),
            .mem_addr  (addr[g]),
            .mem_wdata (wdata[g]),
            .mem_strb  (strb[g]),
            .mem_rdata (rdata[g]),
            .mem_ready (ready[g]),
            .busy      (busy[g])
        );
    end

    // ------------------------------------------------------------------
    // Scoreboard state and reference model
    // ------------------------------------------------------------------
    logic [31:0] exp_q[$];
    logic [31:0] mdl_mem [3][1024];
    logic [31:0] mdl_rd  [3];
    int          n_tests = 0;
    int          n_fail  = 0;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp;   // expected read data (reads only)
    } vec_t;

    vec_t tbl [11];

    function automatic int wc(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input int k, input logic w, input logic [15:0] a,
                             input logic [31:0] d, input logic [3:0] s);
        en[k]    = 1'b1;
        wr[k]    = w;
        addr[k]  = a;
        wdata[k] = d;
        strb[k]  = s;
    endtask

    task automatic model_write(input int k, input logic [15:0] a,
                               input logic [31:0] d, input logic [3:0] s);
        logic [9:0] idx;
        idx = a[11:2];
        for (int b = 0; b < 4; b++) begin
            if (s[b]) mdl_mem[k][idx][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    // Waits up to a bounded number of falling edges for mem_ready, then
    // checks latency, read data, pulse width and the held value.
    task automatic wait_resp(input int k, input int lat, input string tag, input logic w,
                             input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        int          n;
        bit          seen;
        logic [31:0] e;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < lat + 8) begin
            @(negedge clk);
            n++;
            if (ready[k]) seen = 1'b1;
        end
        e = exp_q.pop_front();
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: actual no mem_ready required mem_ready after %0d cycles", tag, lat);
            @(posedge clk);
            #1;
            en[k] = 1'b0;
        end else begin
            check({tag, " latency"}, 32'(n), 32'(lat));
            check({tag, " busy"}, 32'(busy[k]), 32'd1);
            check({tag, " rdata"}, rdata[k], e);
            if (w) model_write(k, a, d, s);
            @(posedge clk);
            #1;
            en[k] = 1'b0;
            @(negedge clk);
            check({tag, " ready pulse"}, 32'(ready[k]), 32'd0);
            check({tag, " busy idle"}, 32'(busy[k]), 32'd0);
            check({tag, " rdata held"}, rdata[k], e);
        end
    endtask

    task automatic do_access(input int k, input logic w, input logic [15:0] a,
                             input logic [31:0] d, input logic [3:0] s,
                             input bit use_exp, input logic [31:0] exp_c, input string tag);
        logic [31:0] e;
        @(posedge clk);
        #1;
        drive_req(k, w, a, d, s);
        if (w) begin
            e = mdl_rd[k];
        end else begin
            e = use_exp ? exp_c : mdl_mem[k][a[11:2]];
            mdl_rd[k] = e;
        end
        exp_q.push_back(e);
        wait_resp(k, wc(k) + 2, tag, w, a, d, s);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] e;
        logic [15:0] a;
        bit          saw;
        int          served;

        tbl[0]  = '{1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 32'h0};
        tbl[1]  = '{1'b0, 16'h0010, 32'h0,        4'h0, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 16'h0040, 32'h11223344, 4'hF, 32'h0};
        tbl[3]  = '{1'b1, 16'h0040, 32'hAABBCCDD, 4'h5, 32'h0};
        tbl[4]  = '{1'b0, 16'h0040, 32'h0,        4'h0, 32'h11BB33DD};
        tbl[5]  = '{1'b1, 16'h0040, 32'hFFFFFFFF, 4'h0, 32'h0};
        tbl[6]  = '{1'b0, 16'h0040, 32'h0,        4'hF, 32'h11BB33DD};
        tbl[7]  = '{1'b1, 16'h1000, 32'hCAFE0001, 4'hF, 32'h0};
        tbl[8]  = '{1'b0, 16'h0000, 32'h0,        4'h0, 32'hCAFE0001};
        tbl[9]  = '{1'b0, 16'h0003, 32'h0,        4'h0, 32'hCAFE0001};
        tbl[10] = '{1'b0, 16'h0010, 32'h0,        4'h0, 32'hDEADBEEF};

        for (int k = 0; k < 3; k++) begin
            srst[k]   = 1'b1;
            en[k]     = 1'b0;
            wr[k]     = 1'b0;
            addr[k]   = '0;
            wdata[k]  = '0;
            strb[k]   = '0;
            mdl_rd[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) srst[k] = 1'b0;

        // Reset state
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset ready[%0d]", k), 32'(ready[k]), 32'd0);
            check($sformatf("reset busy[%0d]", k),  32'(busy[k]),  32'd0);
            check($sformatf("reset rdata[%0d]", k), rdata[k],      32'd0);
        end

        // Directed table: full/partial/zero-strobe writes, wrap-around
        for (int i = 0; i < 11; i++) begin
            do_access(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb,
                      1'b1, tbl[i].exp, $sformatf("tbl%0d", i));
        end

        // Random accesses against the model on a 16-word window
        for (int i = 0; i < 16; i++) begin
            do_access(0, 1'b1, 16'(16'h0100 + 4*i), $urandom, 4'hF, 1'b0, 32'h0,
                      $sformatf("fill%0d", i));
        end
        for (int i = 0; i < 24; i++) begin
            a = 16'(16'h0100 + 4*$urandom_range(0, 15) + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) a = a | 16'h1000;
            do_access(0, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                      1'b0, 32'h0, $sformatf("rnd%0d", i));
        end

        // WAIT_CYCLES=0: back-to-back reads with mem_en held high
        for (int i = 0; i < 4; i++) begin
            do_access(1, 1'b1, 16'(16'h0200 + 4*i), $urandom, 4'hF, 1'b0, 32'h0,
                      $sformatf("b2b_fill%0d", i));
        end
        @(posedge clk);
        #1;
        drive_req(1, 1'b0, 16'h0200, 32'h0, 4'h0);
        mdl_rd[1] = mdl_mem[1][9'h80];
        exp_q.push_back(mdl_rd[1]);
        served = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            check($sformatf("b2b ready c%0d", n), 32'(ready[1]), 32'(n % 2 == 0));
            check($sformatf("b2b busy c%0d", n),  32'(busy[1]),  32'(n % 2 == 0));
            if (n % 2 == 0) begin
                e = exp_q.pop_front();
                check($sformatf("b2b rdata %0d", served), rdata[1], e);
                @(posedge clk);
                #1;
                if (served < 3) begin
                    addr[1]   = 16'(16'h0200 + 4*(served + 1));
                    mdl_rd[1] = mdl_mem[1][addr[1][11:2]];
                    exp_q.push_back(mdl_rd[1]);
                end else begin
                    en[1] = 1'b0;
                end
                served++;
            end
        end
        @(negedge clk);
        check("b2b end ready", 32'(ready[1]), 32'd0);
        check("b2b end rdata", rdata[1], mdl_rd[1]);

        // Reset during WAIT of a write, then a request right after reset
        do_access(0, 1'b1, 16'h0020, 32'h0, 4'hF, 1'b0, 32'h0, "rst_pre_wr");
        do_access(0, 1'b0, 16'h0010, 32'h0, 4'h0, 1'b0, 32'h0, "rst_pre_rd");
        @(posedge clk);
        #1;
        drive_req(0, 1'b1, 16'h0020, 32'h12345678, 4'hF);
        @(negedge clk);
        @(negedge clk);
        check("rst in wait busy",  32'(busy[0]),  32'd1);
        check("rst in wait ready", 32'(ready[0]), 32'd0);
        srst[0] = 1'b1;
        @(posedge clk);
        #1;
        srst[0] = 1'b0;
        mdl_rd[0] = 32'h0;
        drive_req(0, 1'b0, 16'h0020, 32'h0, 4'hF);
        exp_q.push_back(mdl_mem[0][8]);
        mdl_rd[0] = mdl_mem[0][8];
        @(negedge clk);
        check("rst after ready", 32'(ready[0]), 32'd0);
        check("rst after busy",  32'(busy[0]),  32'd0);
        check("rst after rdata", rdata[0],      32'd0);
        wait_resp(0, wc(0) + 1, "rst_post_rd", 1'b0, 16'h0020, 32'h0, 4'h0);

        // WAIT_CYCLES=3: mem_en dropped in the second WAIT cycle of a write
        do_access(2, 1'b1, 16'h0030, 32'h55AA55AA, 4'hF, 1'b0, 32'h0, "abort_pre_wr");
        do_access(2, 1'b0, 16'h0030, 32'h0, 4'h0, 1'b0, 32'h0, "abort_pre_rd");
        @(posedge clk);
        #1;
        drive_req(2, 1'b1, 16'h0030, 32'hFFFFFFFF, 4'hF);
        @(negedge clk);
        @(negedge clk);
        check("abort wait1 busy",  32'(busy[2]),  32'd1);
        check("abort wait1 ready", 32'(ready[2]), 32'd0);
        @(posedge clk);
        #1;
        en[2] = 1'b0;
        @(negedge clk);
        check("abort wait2 busy", 32'(busy[2]), 32'd1);
        @(negedge clk);
        check("abort idle busy",  32'(busy[2]),  32'd0);
        check("abort idle rdata", rdata[2],      mdl_rd[2]);
        saw = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ready[2] || busy[2]) saw = 1'b1;
        end
        check("abort stays idle", 32'(saw), 32'd0);
        do_access(2, 1'b0, 16'h0030, 32'h0, 4'h0, 1'b0, 32'h0, "abort_post_rd");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual simulation still running required finished by 300000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/friscv_dmem_responder.md
FRISCV_DMEM_RESPONDER -- requirements
Module: friscv_dmem_responder

Interface
REQ-001 SHALL have parameter ADDRW, default 16: byte-address width of mem_addr.
REQ-002 SHALL have parameter XLEN, default 32: data width; only 32 is supported.
REQ-003 SHALL have parameter DEPTH, default 1024: storage size in XLEN words; power of two, 2..65536.
REQ-004 SHALL have parameter WAIT_CYCLES, default 1: wait states inserted per access, legal range 0..15.
REQ-005 SHALL have port aclk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-006 SHALL have port srst, input, 1 bit: reset, synchronous to aclk and active-high.
REQ-007 SHALL have port mem_en, input, 1 bit: the initiator holds a request active.
REQ-008 SHALL have port mem_wr, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port mem_addr, input, ADDRW bits: byte address.
REQ-010 SHALL have port mem_wdata, input, XLEN bits: write data.
REQ-011 SHALL have port mem_strb, input, XLEN/8 bits: per-byte write enables.
REQ-012 SHALL have port mem_rdata, output, XLEN bits: read data.
REQ-013 SHALL have port mem_ready, output, 1 bit: a one-cycle completion pulse.
REQ-014 SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-015 SHALL implement the responder end of the core data-memory interface: the initiator holds mem_en/mem_wr/mem_addr/mem_wdata/mem_strb stable until it sees mem_ready=1.
REQ-016 SHALL run an FSM with states IDLE, WAIT, RESP.
REQ-017 IDLE: if mem_en=1 at an edge, SHALL capture mem_wr, mem_addr, mem_wdata and mem_strb into registers.
REQ-018 From IDLE, SHALL go to WAIT when WAIT_CYCLES>0, else directly to RESP.
REQ-019 WAIT: a 4-bit counter SHALL load WAIT_CYCLES-1 on entry and decrement each cycle; SHALL go to RESP on the cycle the counter is 0.
REQ-020 RESP: mem_ready SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-021 Latency: a request sampled at edge t SHALL have mem_ready=1 during cycle t+1+WAIT_CYCLES.
REQ-022 mem_ready SHALL be 0 in IDLE and WAIT.
REQ-023 Word index SHALL be captured mem_addr[log2(DEPTH)+1:2]; upper address bits and addr[1:0] SHALL be ignored, so out-of-range addresses wrap modulo DEPTH.
REQ-024 Write: on the edge that leaves RESP, SHALL update only byte lanes whose strb bit is 1; strb=0 SHALL complete normally with no storage change.
REQ-025 Read: mem_rdata SHALL present the full stored word during the RESP cycle and hold that value until the next read completes; strb SHALL be ignored for reads.
REQ-026 A write completion SHALL NOT change mem_rdata.
REQ-027 Back-to-back: mem_en still 1 in the IDLE cycle after RESP SHALL be treated as a new request, giving a throughput of one access per WAIT_CYCLES+2 cycles.
REQ-028 Abort: if mem_en=0 during WAIT or RESP, the FSM SHALL return to IDLE next cycle with no write committed and mem_rdata unchanged.
REQ-029 Inputs SHALL be ignored outside IDLE; the registered copy SHALL be used for the access.
REQ-030 A read following a write to the same word SHALL return the written data (no stale-data hazard).

Reset
REQ-031 While srst=1 at an edge: FSM SHALL go to IDLE, counter to 0, mem_ready to 0, busy to 0 and mem_rdata to 0.
REQ-032 srst SHALL NOT clear storage contents.
REQ-033 srst asserted during WAIT or RESP SHALL cancel the access with no write committed.
REQ-034 A request presented in the first cycle after srst deasserts SHALL be accepted.

Verification
REQ-035 Scenario, WAIT_CYCLES=1: write 0xDEADBEEF to addr 0x0010 with strb=0xF -> mem_ready high for 1 cycle, 2 cycles after the sampling edge. Then read 0x0010 -> mem_rdata=0xDEADBEEF in the RESP cycle and held afterwards.
REQ-036 Scenario, partial write: word 0x11223344, then write 0xAABBCCDD with strb=0x5 -> a subsequent read returns 0x11BB33DD. A write with strb=0x0 -> the word is unchanged and mem_ready still pulses.
REQ-037 Scenario, wrap-around with DEPTH=1024: write 0xCAFE0001 to 0x1000 -> a read of 0x0000 returns 0xCAFE0001. A read of 0x0003 returns the same word.
REQ-038 Scenario, WAIT_CYCLES=0, mem_en held high for 4 reads -> mem_ready pulses every 2nd cycle, busy toggles accordingly, and each read returns the correct data.
REQ-039 Scenario, srst asserted during WAIT of a write to 0x0020 (prior value 0x0) -> mem_ready never pulses, mem_rdata=0, and a later read of 0x0020 returns 0x0.
REQ-040 Scenario, WAIT_CYCLES=3, mem_en dropped in the 2nd WAIT cycle of a write -> no mem_ready, FSM back in IDLE next cycle, storage unchanged.
